// File: rtl/mc_controller.sv
// mc_controller: multi-cycle control unit for the MIPS-subset CPU.
//
// Sequences each instruction through FETCH, DECODE, EXEC_*, MEM_* and WB_* states and drives
// the datapath enables and mux selects from the latched opcode/funct and the ALU zero flag.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   opcode     in   IR[31:26] of the latched instruction
//   funct      in   IR[5:0] of the latched instruction
//   zero       in   ALU result == 0 (used only in BRANCH)
//   state      out  current FSM state code (debug)
//   pc_en      out  PC write enable
//   npc_sel    out  next-PC source: 0 PC+4, 1 branch, 2 jump target, 3 rs (jr)
//   ir_en      out  IR write enable
//   alu_b_sel  out  ALU B operand: 0 rt data, 1 extended imm16
//   ext_op     out  imm16 extension: 0 zero-extend, 1 sign-extend
//   alu_op     out  ALU function: 0 add, 1 sub, 2 or, 3 lui
//   dm_we      out  data-memory write enable
//   rf_we      out  register-file write enable
//   rf_wa_sel  out  write address: 0 rt, 1 rd, 2 $31
//   rf_wd_sel  out  write data: 0 ALU reg, 1 DM reg, 2 PC+4
//   retired    out  count of completed instructions
module mc_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic [3:0]  state,
    output logic        pc_en,
    output logic [1:0]  npc_sel,
    output logic        ir_en,
    output logic        alu_b_sel,
    output logic        ext_op,
    output logic [1:0]  alu_op,
    output logic        dm_we,
    output logic        rf_we,
    output logic [1:0]  rf_wa_sel,
    output logic [1:0]  rf_wd_sel,
    output logic [31:0] retired
);

    localparam logic [3:0] StFetch   = 4'd0;
    localparam logic [3:0] StDecode  = 4'd1;
    localparam logic [3:0] StExecR   = 4'd2;
    localparam logic [3:0] StExecI   = 4'd3;
    localparam logic [3:0] StMemAddr = 4'd4;
    localparam logic [3:0] StMemRd   = 4'd5;
    localparam logic [3:0] StMemWr   = 4'd6;
    localparam logic [3:0] StWbAlu   = 4'd7;
    localparam logic [3:0] StWbMem   = 4'd8;
    localparam logic [3:0] StBranch  = 4'd9;
    localparam logic [3:0] StJump    = 4'd10;

    logic [3:0]  state_q, state_d;
    logic [31:0] retired_q;

    // Instruction decode
    logic is_r, is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;

    always_comb begin
        is_r    = (opcode == 6'b000000);
        is_addu = is_r && (funct == 6'b100001);
        is_subu = is_r && (funct == 6'b100011);
        is_jr   = is_r && (funct == 6'b001000);
        is_ori  = (opcode == 6'b001101);
        is_lui  = (opcode == 6'b001111);
        is_lw   = (opcode == 6'b100011);
        is_sw   = (opcode == 6'b101011);
        is_beq  = (opcode == 6'b000100);
        is_j    = (opcode == 6'b000010);
        is_jal  = (opcode == 6'b000011);
    end

    // Next-state logic
    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch:   state_d = StDecode;
            StDecode: begin
                if (is_addu || is_subu)             state_d = StExecR;
                else if (is_ori || is_lui)          state_d = StExecI;
                else if (is_lw || is_sw)            state_d = StMemAddr;
                else if (is_beq)                    state_d = StBranch;
                else if (is_j || is_jal || is_jr)   state_d = StJump;
                else                                state_d = StFetch;
            end
            StExecR:   state_d = StWbAlu;
            StExecI:   state_d = StWbAlu;
            StMemAddr: state_d = is_lw ? StMemRd : StMemWr;
            StMemRd:   state_d = StWbMem;
            default:   state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Retire on a return to FETCH from a defined, non-FETCH state; recovery from an
    // undefined code is not an instruction completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_q <= 32'd0;
        end else if (state_d == StFetch && state_q != StFetch && state_q <= StJump) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    // Moore outputs, qualified by the latched opcode/funct where needed
    always_comb begin
        pc_en     = 1'b0;
        npc_sel   = 2'd0;
        ir_en     = 1'b0;
        alu_b_sel = 1'b0;
        ext_op    = 1'b0;
        alu_op    = 2'd0;
        dm_we     = 1'b0;
        rf_we     = 1'b0;
        rf_wa_sel = 2'd0;
        rf_wd_sel = 2'd0;
        case (state_q)
            StFetch: begin
                pc_en = 1'b1;
                ir_en = 1'b1;
            end
            StExecR: begin
                alu_op = is_subu ? 2'd1 : 2'd0;
            end
            StExecI: begin
                alu_b_sel = 1'b1;
                alu_op    = is_lui ? 2'd3 : 2'd2;
            end
            StMemAddr: begin
                alu_b_sel = 1'b1;
                ext_op    = 1'b1;
            end
            StMemWr: begin
                // Keep the address computation driven so the store address is stable.
                dm_we     = 1'b1;
                alu_b_sel = 1'b1;
                ext_op    = 1'b1;
            end
            StWbAlu: begin
                rf_we     = 1'b1;
                rf_wa_sel = is_r ? 2'd1 : 2'd0;
            end
            StWbMem: begin
                rf_we     = 1'b1;
                rf_wd_sel = 2'd1;
            end
            StBranch: begin
                alu_op  = 2'd1;
                npc_sel = 2'd1;
                pc_en   = zero;
            end
            StJump: begin
                pc_en   = 1'b1;
                npc_sel = is_jr ? 2'd3 : 2'd2;
                if (is_jal) begin
                    rf_we     = 1'b1;
                    rf_wa_sel = 2'd2;
                    rf_wd_sel = 2'd2;
                end
            end
            default: ;
        endcase
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule
